// File: rtl/floating_point_divider.sv
// Iterative floating-point divider: fp_o = fp_a_i / fp_b_i.
// One operation in flight; restoring division yields one quotient bit per
// cycle, so every operation (specials included) takes FRAC_WIDTH+6 edges.
// Subnormal inputs are flushed to zero, underflow flushes to signed zero,
// rounding is round-to-nearest-even.
module floating_point_divider #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_a_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_b_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
    output logic                          valid_o
);
    localparam int W    = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int MW   = FRAC_WIDTH + 1;   // mantissa with hidden bit
    localparam int QW   = FRAC_WIDTH + 3;   // quotient bits produced
    localparam int RW   = FRAC_WIDTH + 2;   // partial remainder (< 2*divisor)
    localparam int EW   = EXP_WIDTH + 2;    // signed working exponent
    localparam int CW   = $clog2(QW) + 1;
    localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;

    localparam logic signed [EW-1:0]   EXP_BIAS   = EW'(BIAS);
    localparam logic signed [EW-1:0]   EXP_ONE    = EW'(1);
    localparam logic signed [EW-1:0]   EXP_ZERO   = EW'(0);
    localparam logic signed [EW-1:0]   EXP_MAX    = EW'(2 ** EXP_WIDTH - 1);
    localparam logic [CW-1:0]          CNT_LAST   = CW'(QW - 1);
    localparam logic [EXP_WIDTH-1:0]   EXP_ONES   = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]   EXP_ZEROS  = {EXP_WIDTH{1'b0}};
    localparam logic [FRAC_WIDTH-1:0]  FRAC_ZEROS = {FRAC_WIDTH{1'b0}};
    localparam logic [W-1:0]           QNAN       = {1'b0, EXP_ONES, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4
    } state_t;

    state_t                 state_r, state_next_s;
    logic [W-1:0]           a_r, b_r;
    logic                   sign_r, special_r;
    logic [W-1:0]           special_val_r;
    logic signed [EW-1:0]   exp_r;
    logic [MW-1:0]          divisor_r;
    logic [RW-1:0]          rem_r;
    logic [QW-1:0]          quot_r;
    logic [CW-1:0]          cnt_r;
    logic [MW-1:0]          mant_r;
    logic                   guard_r, round_r, sticky_r;

    logic [EXP_WIDTH-1:0]   ea_s, eb_s;
    logic [FRAC_WIDTH-1:0]  fa_s, fb_s;
    logic                   a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic                   sign_s, special_s;
    logic [W-1:0]           special_val_s;
    logic signed [EW-1:0]   exp_diff_s;
    logic [RW-1:0]          diff_s, rem_sel_s, rem_next_s;
    logic                   ge_s;
    logic                   round_up_s;
    logic [MW:0]            mant_sum_s;
    logic [FRAC_WIDTH-1:0]  frac_s;
    logic signed [EW-1:0]   e_fin_s;
    logic [W-1:0]           result_s;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing and the ready handshake (ready only while idle).
    always_comb begin
        state_next_s = state_r;
        ready_o      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next_s = ST_UNPACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_UNPACK: state_next_s = ST_DIVIDE;
            ST_DIVIDE: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_NORM;
                end else begin
                    state_next_s = ST_DIVIDE;
                end
            end
            ST_NORM:  state_next_s = ST_ROUND;
            ST_ROUND: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Operand classification, special-case result and biased exponent difference.
    always_comb begin
        ea_s       = a_r[W-2:FRAC_WIDTH];
        eb_s       = b_r[W-2:FRAC_WIDTH];
        fa_s       = a_r[FRAC_WIDTH-1:0];
        fb_s       = b_r[FRAC_WIDTH-1:0];
        a_zero_s   = (ea_s == EXP_ZEROS);
        b_zero_s   = (eb_s == EXP_ZEROS);
        a_inf_s    = (ea_s == EXP_ONES) && (fa_s == FRAC_ZEROS);
        b_inf_s    = (eb_s == EXP_ONES) && (fb_s == FRAC_ZEROS);
        a_nan_s    = (ea_s == EXP_ONES) && (fa_s != FRAC_ZEROS);
        b_nan_s    = (eb_s == EXP_ONES) && (fb_s != FRAC_ZEROS);
        sign_s     = a_r[W-1] ^ b_r[W-1];
        exp_diff_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + EXP_BIAS;
        special_s     = 1'b1;
        special_val_s = QNAN;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            special_val_s = QNAN;
        end else if (b_zero_s || a_inf_s) begin
            special_val_s = {sign_s, EXP_ONES, FRAC_ZEROS};
        end else if (b_inf_s || a_zero_s) begin
            special_val_s = {sign_s, EXP_ZEROS, FRAC_ZEROS};
        end else begin
            special_s     = 1'b0;
            special_val_s = {sign_s, EXP_ZEROS, FRAC_ZEROS};
        end
    end

    // One restoring-division step: subtract the divisor when it fits, then shift.
    always_comb begin
        diff_s     = rem_r - {1'b0, divisor_r};
        ge_s       = (rem_r >= {1'b0, divisor_r});
        if (ge_s) begin
            rem_sel_s = diff_s;
        end else begin
            rem_sel_s = rem_r;
        end
        rem_next_s = {rem_sel_s[RW-2:0], 1'b0};
    end

    // Round-to-nearest-even, carry renormalisation and range clamping.
    always_comb begin
        round_up_s = guard_r & (round_r | sticky_r | mant_r[0]);
        mant_sum_s = {1'b0, mant_r} + {{MW{1'b0}}, round_up_s};
        if (mant_sum_s[MW]) begin
            frac_s  = mant_sum_s[FRAC_WIDTH:1];
            e_fin_s = exp_r + EXP_ONE;
        end else begin
            frac_s  = mant_sum_s[FRAC_WIDTH-1:0];
            e_fin_s = exp_r;
        end
        if (special_r) begin
            result_s = special_val_r;
        end else if (e_fin_s >= EXP_MAX) begin
            result_s = {sign_r, EXP_ONES, FRAC_ZEROS};
        end else if (e_fin_s <= EXP_ZERO) begin
            result_s = {sign_r, EXP_ZEROS, FRAC_ZEROS};
        end else begin
            result_s = {sign_r, e_fin_s[EXP_WIDTH-1:0], frac_s};
        end
    end

    // Datapath registers advanced by the current state; fp_o held between results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_r           <= {W{1'b0}};
            b_r           <= {W{1'b0}};
            sign_r        <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= {W{1'b0}};
            exp_r         <= EXP_ZERO;
            divisor_r     <= {MW{1'b0}};
            rem_r         <= {RW{1'b0}};
            quot_r        <= {QW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            mant_r        <= {MW{1'b0}};
            guard_r       <= 1'b0;
            round_r       <= 1'b0;
            sticky_r      <= 1'b0;
            fp_o          <= {W{1'b0}};
            valid_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        a_r <= fp_a_i;
                        b_r <= fp_b_i;
                    end
                end
                ST_UNPACK: begin
                    sign_r        <= sign_s;
                    special_r     <= special_s;
                    special_val_r <= special_val_s;
                    exp_r         <= exp_diff_s;
                    divisor_r     <= {1'b1, fb_s};
                    rem_r         <= {1'b0, 1'b1, fa_s};
                    quot_r        <= {QW{1'b0}};
                    cnt_r         <= {CW{1'b0}};
                end
                ST_DIVIDE: begin
                    rem_r  <= rem_next_s;
                    quot_r <= {quot_r[QW-2:0], ge_s};
                    cnt_r  <= cnt_r + CW'(1);
                end
                ST_NORM: begin
                    sticky_r <= |rem_r;
                    if (quot_r[QW-1]) begin
                        mant_r  <= quot_r[QW-1:2];
                        guard_r <= quot_r[1];
                        round_r <= quot_r[0];
                    end else begin
                        mant_r  <= quot_r[QW-2:1];
                        guard_r <= quot_r[0];
                        round_r <= 1'b0;
                        exp_r   <= exp_r - EXP_ONE;
                    end
                end
                ST_ROUND: begin
                    fp_o    <= result_s;
                    valid_o <= 1'b1;
                end
                default: begin
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_divider.sv
// Scoreboard bench for floating_point_divider (FP32): directed vectors with
// hand-computed quotients, handshake with valid held high, and reset mid-op.
module tb_floating_point_divider;
    localparam int LAT = 29;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] fp_a_i, fp_b_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] fp_o;
    logic        valid_o;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [31:0] exp_q [$];
    int          acc_q [$];

    floating_point_divider #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .fp_a_i  (fp_a_i),
        .fp_b_i  (fp_b_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .fp_o    (fp_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present operands and keep valid_i high until an edge with ready_o high takes them.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                        input bit keep_valid);
        int  waited = 0;
        bit  acc    = 1'b0;
        fp_a_i  = a;
        fp_b_i  = b;
        valid_i = 1'b1;
        while (!acc && waited < 200) begin
            acc = ready_o;
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (acc) begin
            exp_q.push_back(expv);
            acc_q.push_back(cyc);
        end else begin
            total++;
            $display("FAIL accept_timeout: actual no accept required accept for %h/%h", a, b);
        end
        if (!keep_valid) valid_i = 1'b0;
    endtask

    // Wait (bounded) for every expected result to come out.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // Monitor: compare each valid_o pulse with the scoreboard head.
    initial begin : monitor
        logic [31:0] e;
        int          c;
        logic        prev_valid = 1'b0;
        forever begin
            @(negedge clk_i);
            if (prev_valid && !rst_i) check("valid_pulse_width", {31'd0, valid_o}, 32'd0);
            if (valid_o && !rst_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: actual %h required no output", fp_o);
                end else begin
                    e = exp_q.pop_front();
                    c = acc_q.pop_front();
                    check("result", fp_o, e);
                    check("latency", 32'(cyc - c), 32'(LAT));
                    check("ready_in_valid_cycle", {31'd0, ready_o}, 32'd1);
                end
            end
            prev_valid = valid_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] va [23] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                             32'h00000000, 32'h7F800000, 32'h40A00000, 32'h7FC00001, 32'h7F000000,
                             32'h00800000, 32'h00000001, 32'hC0C00000, 32'h40000000, 32'h7F7FFFFF,
                             32'h00800000, 32'h3F800000, 32'hC0A00000, 32'h7F800000, 32'h00000000,
                             32'h3F800000, 32'h80800000, 32'h40E00000};
    logic [31:0] vb [23] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
                             32'h00000000, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h3E800000,
                             32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                             32'h3F800000, 32'h80000000, 32'h7F800000, 32'hC0A00000, 32'h40A00000,
                             32'h7F800001, 32'h40000000, 32'h40000000};
    logic [31:0] vq [23] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                             32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
                             32'h00000000, 32'h00000000, 32'hC0400000, 32'h3F2AAAAB, 32'h7F7FFFFF,
                             32'h00800000, 32'hFF800000, 32'h80000000, 32'hFF800000, 32'h00000000,
                             32'h7FC00000, 32'h80000000, 32'h40600000};

    initial begin : stimulus
        rst_i   = 1'b1;
        valid_i = 1'b0;
        fp_a_i  = 32'h0;
        fp_b_i  = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_fp_o", fp_o, 32'h0);
        check("reset_valid_o", {31'd0, valid_o}, 32'd0);
        check("reset_ready_o", {31'd0, ready_o}, 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Directed vectors, one at a time.
        for (int i = 0; i < 23; i++) begin
            send(va[i], vb[i], vq[i], 1'b0);
            drain();
        end

        // valid_i held high across three operand pairs: each accepted exactly once.
        send(32'h40E00000, 32'h40000000, 32'h40600000, 1'b1);
        check("busy_ready_low", {31'd0, ready_o}, 32'd0);
        send(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b1);
        send(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0);
        drain();

        // Reset 10 cycles into an operation: outputs clear at once, result never appears.
        send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("midop_reset_fp_o", fp_o, 32'h0);
        check("midop_reset_valid_o", {31'd0, valid_o}, 32'd0);
        check("midop_reset_ready_o", {31'd0, ready_o}, 32'd1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        check("post_reset_fp_o_idle", fp_o, 32'h0);
        send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        drain();

        repeat (3) @(posedge clk_i);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
